uart_rx_capture: RTL

Parametrised, synthesizable UART receive monitor with an elastic output buffer; successor to the fixed 8N1 bus model used on the pulpino uart_tx path.
- Frame format: configurable data width, parity (none/even/odd), 1 or 2 stop bits.
- Per-byte error tagging, break detection and sticky overflow.
- Usable both in benches and on FPGA builds to capture SoC console output.
- Sits on the SoC uart_tx pad and presents received characters via a valid/ready stream.

---
 rtl/uart_rx_capture_pkg.sv | 20 ++
 rtl/uart_capture_fifo.sv | 75 +++++++
 rtl/uart_rx_capture.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_capture_pkg.sv
// Shared types and helpers for the UART receive capture block.
package uart_rx_capture_pkg;

  localparam int unsigned MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Parity bit a correct transmitter would send for this data word.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_capture_fifo.sv
// First-word-fall-through FIFO with synchronous clear and occupancy count.
module uart_capture_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so push-while-full succeeds only alongside a pop.
  always_comb begin
    do_pop   = pop_i & ~empty_q & ~clr_i;
    do_push  = push_i & (~full_q | do_pop) & ~clr_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + LW'(do_push) - LW'(do_pop);
    end
    full_d  = (count_d == LW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Stale storage is masked so an empty FIFO presents zeros.
  assign rdata_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = count_q;

endmodule

// File: rtl/uart_rx_capture.sv
// UART receive monitor: oversampled frame decoder feeding an FWFT buffer with error tags.
module uart_rx_capture
  import uart_rx_capture_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overflow_o,
  output logic                          break_o,
  input  logic                          clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $fatal(1, "uart_rx_capture: DATA_BITS must be 5..8");
  end
  if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_parity
    $fatal(1, "uart_rx_capture: PARITY_EN and PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_rx_capture: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $fatal(1, "uart_rx_capture: CLKS_PER_BIT must be >= 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_rx_capture: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rxs_q, rxs_d;
  logic                 rxs_prev_q, rxs_prev_d;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 break_q, break_d;
  logic                 overflow_q, overflow_d;

  logic                 fall_c;
  logic                 mid_bit_c;
  logic                 ferr_now_c;
  logic                 push_c;
  logic                 pop_fire_c;
  entry_t               push_entry_c;
  entry_t               head_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;

  always_comb begin
    rx_meta_d  = rx_i;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
  end

  assign fall_c     = rxs_prev_q & ~rxs_q;
  assign mid_bit_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign ferr_now_c = ferr_q | ~rxs_q;

  // Frame decoder; after the start-bit midpoint every sample lands one full bit later.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    break_d      = break_q;
    push_c       = 1'b0;
    push_entry_c = '{ferr: ferr_now_c, perr: perr_q, data: shift_q};

    unique case (state_q)
      ST_IDLE: begin
        if (rx_en_i && fall_c) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT / 2)) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (mid_bit_c) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (mid_bit_c) begin
          cnt_d   = '0;
          perr_d  = rxs_q != parity_calc(MAX_DATA_BITS'(shift_q), 1'(PARITY_ODD));
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (mid_bit_c) begin
          cnt_d  = '0;
          ferr_d = ferr_now_c;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            push_c = 1'b1;
            if (shift_q == '0 && !rxs_q) begin
              state_d = ST_BREAK;
              break_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
          break_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the receiver abandons any partial frame without touching the buffer.
    if (!rx_en_i && (state_q == ST_START || state_q == ST_DATA ||
                     state_q == ST_PARITY || state_q == ST_STOP)) begin
      state_d = ST_IDLE;
      push_c  = 1'b0;
      break_d = break_q;
    end
  end

  assign pop_fire_c = valid_o & ready_i;

  always_comb begin
    overflow_d = overflow_q;
    if (clr_i) begin
      overflow_d = 1'b0;
    end else if (push_c && fifo_full && !pop_fire_c) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      break_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      break_q    <= break_d;
      overflow_q <= overflow_d;
    end
  end

  uart_capture_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_i),
    .push_i  (push_c),
    .wdata_i (push_entry_c),
    .pop_i   (ready_i),
    .rdata_o (head_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign data_o     = head_c.data;
  assign perr_o     = head_c.perr;
  assign ferr_o     = head_c.ferr;
  assign valid_o    = ~fifo_empty;
  assign level_o    = fifo_level;
  assign overflow_o = overflow_q;
  assign break_o    = break_q;

endmodule
